// File: rtl/cpu_stage_5_wb_pkg.sv
// Shared LC-3b pipeline types: opcodes, the pipeline control word and the WB FSM states.
package cpu_stage_5_wb_pkg;

  localparam logic [3:0] op_br   = 4'b0000;
  localparam logic [3:0] op_add  = 4'b0001;
  localparam logic [3:0] op_ldb  = 4'b0010;
  localparam logic [3:0] op_jsr  = 4'b0100;
  localparam logic [3:0] op_ldr  = 4'b0110;
  localparam logic [3:0] op_ldi  = 4'b1010;
  localparam logic [3:0] op_jmp  = 4'b1100;
  localparam logic [3:0] op_lea  = 4'b1110;
  localparam logic [3:0] op_trap = 4'b1111;

  localparam logic [15:0] nop = 16'h0000;

  typedef enum logic {IDLE, REDIRECT} wb_state_t;

  typedef struct packed {
    logic [15:0] instruction;
    logic [15:0] pc;              // already PC+2
    logic [15:0] alu_out;
    logic [15:0] mem_out;
    logic [15:0] calc_adrs_out;
    logic [15:0] resolved_target;
    logic [2:0]  dr;
    logic        ld_regfile;
    logic        ld_cc;
  } pipeline_ctrl;

endpackage

// File: rtl/cpu_stage_5_wb_gencc.sv
// Condition-code generator: 16-bit value -> one-hot NZP. Shared with the memory stage.
module cpu_gencc (
  input  logic [15:0] data,
  output logic [2:0]  nzp
);

  always_comb begin
    if (data[15])            nzp = 3'b100;
    else if (data == 16'h0)  nzp = 3'b010;
    else                     nzp = 3'b001;
  end

endmodule

// File: rtl/cpu_stage_5_wb.sv
// LC-3b writeback stage: regfile write, NZP register, control-transfer redirect/flush.
// Optional retirement counters are built only when WB_PERF_CNT_EN is defined.
module cpu_stage_5_wb
  import cpu_stage_5_wb_pkg::*;
#(
  parameter int         CNT_WIDTH = 32,
  parameter logic [2:0] CC_RESET  = 3'b010
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall_all,
  input  pipeline_ctrl         ctrl_w_in,
  output logic                 rf_we,
  output logic [2:0]           rf_dest,
  output logic [15:0]          rf_data,
  output logic                 wb_fwd_valid,
  output logic [15:0]          wb_fwd_data,
  output logic [2:0]           cc_out,
  output logic                 pc_redirect,
  output logic [15:0]          redirect_target,
  output logic                 flush_pipe,
  output logic [CNT_WIDTH-1:0] retired_count,
  output logic [CNT_WIDTH-1:0] taken_count
);

  wb_state_t   state, state_next;
  logic [3:0]  opc;
  logic        live, take, fire, is_link;
  logic [2:0]  cc_new;

  assign opc     = ctrl_w_in.instruction[15:12];
  assign is_link = (opc == op_jsr) || (opc == op_trap);
  // Reset is folded in so the write port is quiet while reset is held.
  assign live    = (ctrl_w_in.instruction != nop) && (state == IDLE) && !reset;
  assign fire    = take && !stall_all;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    rf_data = ctrl_w_in.alu_out;
    unique case (opc)
      op_ldb, op_ldr, op_ldi: rf_data = ctrl_w_in.mem_out;
      op_lea:                 rf_data = ctrl_w_in.calc_adrs_out;
      op_jsr, op_trap:        rf_data = ctrl_w_in.pc;
      default:                rf_data = ctrl_w_in.alu_out;
    endcase
  end

  assign rf_dest      = is_link ? 3'd7 : ctrl_w_in.dr;
  assign rf_we        = live && ctrl_w_in.ld_regfile && !stall_all;
  assign wb_fwd_valid = rf_we;
  assign wb_fwd_data  = rf_data;

  always_comb begin
    take = 1'b0;
    if (live) begin
      if (opc == op_br)                                      take = |(ctrl_w_in.instruction[11:9] & cc_out);
      else if (opc == op_jmp || opc == op_jsr || opc == op_trap) take = 1'b1;
    end
  end

  cpu_gencc u_gencc (
    .data (rf_data),
    .nzp  (cc_new)
  );

  // State register plus the registers that load alongside it.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state           <= IDLE;
      cc_out          <= CC_RESET;
      redirect_target <= 16'h0000;
    end else begin
      state <= state_next;
      if (live && ctrl_w_in.ld_cc && !stall_all) cc_out <= cc_new;
      if (fire)                                  redirect_target <= ctrl_w_in.resolved_target;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (fire)       state_next = REDIRECT;
      REDIRECT: if (!stall_all) state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  always_comb begin
    pc_redirect = (state == REDIRECT);
    flush_pipe  = (state == REDIRECT);
  end

`ifdef WB_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_count <= '0;
      taken_count   <= '0;
    end else begin
      if (live && !stall_all) retired_count <= retired_count + CNT_WIDTH'(1);
      if (fire)               taken_count   <= taken_count + CNT_WIDTH'(1);
    end
  end
`else
  assign retired_count = '0;
  assign taken_count   = '0;
`endif

endmodule

// File: tb/tb_cpu_stage_5_wb.sv
// Directed self-checking bench for the LC-3b writeback stage.
module tb_cpu_stage_5_wb;
  import cpu_stage_5_wb_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         stall_all;
  pipeline_ctrl ctrl;
  logic         rf_we, wb_fwd_valid, pc_redirect, flush_pipe;
  logic [2:0]   rf_dest, cc_out;
  logic [15:0]  rf_data, wb_fwd_data, redirect_target;
  logic [31:0]  retired_count, taken_count;

  int checks   = 0;
  int failures = 0;
  int exp_ret  = 0;
  int exp_tk   = 0;

  cpu_stage_5_wb #(.CNT_WIDTH(32), .CC_RESET(3'b010)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall_all       (stall_all),
    .ctrl_w_in       (ctrl),
    .rf_we           (rf_we),
    .rf_dest         (rf_dest),
    .rf_data         (rf_data),
    .wb_fwd_valid    (wb_fwd_valid),
    .wb_fwd_data     (wb_fwd_data),
    .cc_out          (cc_out),
    .pc_redirect     (pc_redirect),
    .redirect_target (redirect_target),
    .flush_pipe      (flush_pipe),
    .retired_count   (retired_count),
    .taken_count     (taken_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Counters read as zero when the perf-counter build option is off.
  function automatic logic [31:0] cnt(input int v);
`ifdef WB_PERF_CNT_EN
    return 32'(v);
`else
    return 32'(v * 0);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctrl(input logic [15:0] instr, input logic [15:0] pc, input logic [15:0] alu,
                          input logic [15:0] mem, input logic [15:0] adrs, input logic [15:0] tgt,
                          input logic [2:0] dr, input logic ldr, input logic ldc);
    ctrl.instruction     = instr;
    ctrl.pc              = pc;
    ctrl.alu_out         = alu;
    ctrl.mem_out         = mem;
    ctrl.calc_adrs_out   = adrs;
    ctrl.resolved_target = tgt;
    ctrl.dr              = dr;
    ctrl.ld_regfile      = ldr;
    ctrl.ld_cc           = ldc;
    #1;
  endtask

  task automatic set_nop();
    set_ctrl(nop, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_counts(input string name);
    chk({name, ".retired"}, retired_count, cnt(exp_ret));
    chk({name, ".taken"},   taken_count,   cnt(exp_tk));
  endtask

  task automatic test_reset();
    reset = 1'b1; stall_all = 1'b0;
    set_nop();
    tick();
    chk("rst.cc",       32'(cc_out), 32'h2);
    chk("rst.redirect", 32'(pc_redirect), 32'h0);
    chk("rst.flush",    32'(flush_pipe), 32'h0);
    chk("rst.target",   32'(redirect_target), 32'h0);
    chk("rst.rf_we",    32'(rf_we), 32'h0);
    chk_counts("rst");
    #2 reset = 1'b0;
  endtask

  task automatic test_add();
    tick();
    set_ctrl(16'h1240, 16'h0, 16'h8000, 16'h0, 16'h0, 16'h0, 3'd1, 1'b1, 1'b1);
    chk("add.rf_we",     32'(rf_we), 32'h1);
    chk("add.rf_dest",   32'(rf_dest), 32'h1);
    chk("add.rf_data",   32'(rf_data), 32'h8000);
    chk("add.fwd_valid", 32'(wb_fwd_valid), 32'h1);
    chk("add.fwd_data",  32'(wb_fwd_data), 32'h8000);
    tick(); exp_ret++;
    set_nop();
    chk("add.cc", 32'(cc_out), 32'h4);
    chk_counts("add");
  endtask

  task automatic test_ldr();
    set_ctrl(16'h6440, 16'h0, 16'h1234, 16'h0000, 16'h0, 16'h0, 3'd2, 1'b1, 1'b1);
    chk("ldr.rf_data", 32'(rf_data), 32'h0);
    chk("ldr.rf_dest", 32'(rf_dest), 32'h2);
    tick(); exp_ret++;
    set_nop();
    chk("ldr.cc", 32'(cc_out), 32'h2);
  endtask

  task automatic test_lea();
    set_ctrl(16'hE600, 16'h0, 16'h1111, 16'h2222, 16'h3333, 16'h0, 3'd3, 1'b1, 1'b0);
    chk("lea.rf_data", 32'(rf_data), 32'h3333);
    tick(); exp_ret++;
    set_nop();
    chk("lea.cc_hold", 32'(cc_out), 32'h2);
  endtask

  task automatic test_br_taken();
    set_ctrl(16'h1660, 16'h0, 16'h0005, 16'h0, 16'h0, 16'h0, 3'd3, 1'b1, 1'b1);
    tick(); exp_ret++;
    chk("brt.cc_pre", 32'(cc_out), 32'h1);
    set_ctrl(16'h0200, 16'h0, 16'h0, 16'h0, 16'h0, 16'h3000, 3'd0, 1'b0, 1'b0);
    chk("brt.no_redirect_yet", 32'(pc_redirect), 32'h0);
    tick(); exp_ret++; exp_tk++;
    set_ctrl(16'h1240, 16'h0, 16'h8000, 16'h0, 16'h0, 16'h0, 3'd1, 1'b1, 1'b1);
    chk("brt.redirect", 32'(pc_redirect), 32'h1);
    chk("brt.flush",    32'(flush_pipe), 32'h1);
    chk("brt.target",   32'(redirect_target), 32'h3000);
    chk("brt.squash_we", 32'(rf_we), 32'h0);
    tick();
    set_nop();
    chk("brt.redirect_off", 32'(pc_redirect), 32'h0);
    chk("brt.cc_kept",      32'(cc_out), 32'h1);
    chk_counts("brt");
  endtask

  task automatic test_br_not_taken();
    set_ctrl(16'h1660, 16'h0, 16'h0000, 16'h0, 16'h0, 16'h0, 3'd3, 1'b1, 1'b1);
    tick(); exp_ret++;
    chk("brn.cc_pre", 32'(cc_out), 32'h2);
    set_ctrl(16'h0800, 16'h0, 16'h0, 16'h0, 16'h0, 16'h5555, 3'd0, 1'b0, 1'b0);
    tick(); exp_ret++;
    set_nop();
    chk("brn.redirect", 32'(pc_redirect), 32'h0);
    chk("brn.target",   32'(redirect_target), 32'h3000);
    chk_counts("brn");
  endtask

  task automatic test_trap();
    set_ctrl(16'hF025, 16'h0402, 16'h0, 16'h2000, 16'h0, 16'h2000, 3'd0, 1'b1, 1'b0);
    chk("trap.rf_we",   32'(rf_we), 32'h1);
    chk("trap.rf_dest", 32'(rf_dest), 32'h7);
    chk("trap.rf_data", 32'(rf_data), 32'h0402);
    tick(); exp_ret++; exp_tk++;
    set_nop();
    chk("trap.redirect", 32'(pc_redirect), 32'h1);
    chk("trap.target",   32'(redirect_target), 32'h2000);
    tick();
    chk("trap.redirect_off", 32'(pc_redirect), 32'h0);
    chk_counts("trap");
  endtask

  task automatic test_stall_freeze();
    stall_all = 1'b1;
    set_ctrl(16'h1240, 16'h0, 16'h8000, 16'h0, 16'h0, 16'h0, 3'd1, 1'b1, 1'b1);
    chk("stall.rf_we",   32'(rf_we), 32'h0);
    chk("stall.rf_data", 32'(rf_data), 32'h8000);
    tick();
    chk("stall.cc", 32'(cc_out), 32'h2);
    chk_counts("stall");
    stall_all = 1'b0;
    set_nop();
  endtask

  task automatic test_stall_redirect();
    set_ctrl(16'hC1C0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h4444, 3'd0, 1'b0, 1'b0);
    tick(); exp_ret++; exp_tk++;
    stall_all = 1'b1;
    set_nop();
    chk("stlr.cycle1", 32'(pc_redirect), 32'h1);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk($sformatf("stlr.cycle%0d", i), 32'(pc_redirect), 32'h1);
      chk($sformatf("stlr.flush%0d", i), 32'(flush_pipe), 32'h1);
    end
    stall_all = 1'b0;
    #1;
    tick();
    chk("stlr.drop",   32'(pc_redirect), 32'h0);
    chk("stlr.target", 32'(redirect_target), 32'h4444);
    chk_counts("stlr");
  endtask

  task automatic test_back_to_back();
    set_ctrl(16'hC1C0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h5000, 3'd0, 1'b0, 1'b0);
    tick(); exp_ret++; exp_tk++;
    set_ctrl(16'hC080, 16'h0, 16'h0, 16'h0, 16'h0, 16'h6000, 3'd0, 1'b0, 1'b0);
    chk("b2b.redirect", 32'(pc_redirect), 32'h1);
    chk("b2b.target",   32'(redirect_target), 32'h5000);
    tick();
    set_nop();
    chk("b2b.second_squashed", 32'(pc_redirect), 32'h0);
    chk("b2b.target_kept",     32'(redirect_target), 32'h5000);
    chk_counts("b2b");
  endtask

  task automatic test_reset_mid_redirect();
    set_ctrl(16'hC1C0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h7000, 3'd0, 1'b0, 1'b0);
    tick();
    set_ctrl(16'h1240, 16'h0, 16'h8000, 16'h0, 16'h0, 16'h0, 3'd1, 1'b1, 1'b1);
    chk("rmr.redirect_before", 32'(pc_redirect), 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("rmr.redirect", 32'(pc_redirect), 32'h0);
    chk("rmr.flush",    32'(flush_pipe), 32'h0);
    chk("rmr.rf_we",    32'(rf_we), 32'h0);
    chk("rmr.cc",       32'(cc_out), 32'h2);
    chk("rmr.target",   32'(redirect_target), 32'h0);
    exp_ret = 0; exp_tk = 0;
    chk_counts("rmr");
    #1 reset = 1'b0;
    set_nop();
  endtask

  initial begin
    test_reset();
    test_add();
    test_ldr();
    test_lea();
    test_br_taken();
    test_br_not_taken();
    test_trap();
    test_stall_freeze();
    test_stall_redirect();
    test_back_to_back();
    test_reset_mid_redirect();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
